seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle counterpart of the combinational barrel shifter: accepts one shift request through a valid/ready handshake.
- Shifts one position per clock, keeping a sticky overflow flag, and returns the result through a second valid/ready handshake.
- Used where area matters more than latency, or where shift requests arrive from a handshake-based datapath.

Parameters:
- bit_size, 8, data width in bits; must be ≥ 2 and a power of 2.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; equals (state==IDLE).
- data  input  bit_size  operand.
- num_shift  input  $clog2(bit_size)  shift amount, 0..bit_size-1.
- direction  input  1  0 = left, 1 = right.
- sel  input  2  0 = logical, 1 = arithmetic, 2 = rotate, 3 = reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  bit_size  shifted result, registered.
- overflow  output  1  sticky overflow, registered.
- busy  output  1  state != IDLE.

Behaviour:
- Interface rules fixed for this block: single clock clk; reset rstn is asynchronous and active-low.
- Reset values: state=IDLE, out=0, overflow=0, out_valid=0, busy=0, internal count=0. in_ready=1 while in reset and after release.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on in_valid & in_ready, latch data into out, and latch num_shift, direction and sel. Clear overflow, set count=num_shift, go to SHIFT.
- SHIFT with count!=0: apply one-position step, count-=1, stay in SHIFT. With count==0: go to DONE.
- DONE: out_valid=1. out and overflow are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency: out_valid rises num_shift+1 clock edges after the acceptance edge, including when num_shift=0.
- Throughput: no overlap; next acceptance is earliest in the cycle after the output handshake.
- Step rules:
  - Logical left: shift left with 0 fill; overflow |= bit shifted out.
  - Logical right: shift right with 0 fill; overflow unchanged.
  - Arithmetic left: 0 fill; overflow |= (new MSB != old MSB).
  - Arithmetic right: MSB replicated; overflow unchanged.
  - Rotate left/right: bit wraps around; overflow unchanged.
  - sel=3: out unchanged each step, overflow=0, latency unchanged.
- Boundary and corner cases:
  - in_valid while busy is ignored, and the request is not latched.
  - Input ports are don't-care after acceptance.
  - out_ready while not in DONE has no effect.
  - out_ready held high in DONE gives a one-cycle out_valid pulse.
  - rstn low at any point aborts the operation immediately and discards it; outputs go to reset values.
  - Internal count width is $clog2(bit_size); it never wraps because it decrements only when nonzero.

Optional Feature:
- SEQ_SHIFTER_FAST_EN defined: each SHIFT cycle shifts 2 positions while count≥2, otherwise 1.
  - count decrements by the step size.
  - Overflow is accumulated over both positions: either shifted-out bit, or any MSB change at either intermediate position.
  - Latency is ceil(num_shift/2)+1.
  - Final out and overflow are identical to the non-fast mode.
- Not defined: one position per cycle as above.

Decomposition:
- Package shifter_pkg:
  - sel encodings SEL_LOGIC=2'd0, SEL_ARITH=2'd1, SEL_ROT=2'd2.
  - direction encodings DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - FSM state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module seq_shift_step: combinational single step.
  - Inputs: value, direction, sel, step count (1 or 2).
  - Outputs: next value and step overflow.
  - seq_shifter instantiates it once.

Test Plan (bit_size=8, out_ready=1 unless stated):
- data=0x96, n=3, left, sel=0 → out=0xB0, overflow=1, out_valid 4 edges after acceptance.
- data=0x96, n=2, right, sel=1 → out=0xE5, overflow=0, latency 3.
- data=0x96, n=3, left, sel=2 → out=0xB4, overflow=0; then same operands with right → out=0xD2.
- data=0x30, n=2, left, sel=1 → out=0xC0, overflow=1. Then data=0x30, n=1 → out=0x60, overflow=0.
- data=0x5A, n=0, sel=0 → out=0x5A after 1 edge. Hold out_ready=0 for 5 cycles: out_valid stays 1, out stays stable, in_ready=0, and in_valid pulses with data=0xFF are ignored. Release out_ready → in_ready=1 next cycle.
- Start n=7, left, sel=0; assert rstn low 3 cycles after acceptance → out=0, overflow=0, out_valid=0 immediately. After release, data=0x01, n=7, left, sel=0 → out=0x80, overflow=0.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation select, shift direction and FSM states.
// Build option SEQ_SHIFTER_FAST_EN (consumed by seq_shifter.sv) enables two-position steps.
package shifter_pkg;

  localparam logic [1:0] SEL_LOGIC = 2'd0;
  localparam logic [1:0] SEL_ARITH = 2'd1;
  localparam logic [1:0] SEL_ROT   = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_step.sv
// Combinational shift step of one or two positions, reporting the overflow produced by the step.
// Selector value 3 passes the value through unchanged with no overflow.
module seq_shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             direction_i,
  input  logic [1:0]       sel_i,
  input  logic             double_i,
  output logic [WIDTH-1:0] value_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] midValue;
  logic [WIDTH-1:0] finValue;
  logic             midOvf;
  logic             finOvf;

  // Returns {overflow, value} for a single-position move.
  function automatic logic [WIDTH:0] stepOnce(input logic [WIDTH-1:0] v,
                                              input logic             dir,
                                              input logic [1:0]       s);
    logic [WIDTH-1:0] nv;
    logic             ov;
    nv = v;
    ov = 1'b0;
    case (s)
      SEL_LOGIC: begin
        if (dir == DIR_LEFT) begin
          nv = {v[WIDTH-2:0], 1'b0};
          ov = v[WIDTH-1];
        end else begin
          nv = {1'b0, v[WIDTH-1:1]};
        end
      end
      SEL_ARITH: begin
        if (dir == DIR_LEFT) begin
          nv = {v[WIDTH-2:0], 1'b0};
          ov = v[WIDTH-1] ^ v[WIDTH-2];
        end else begin
          nv = {v[WIDTH-1], v[WIDTH-1:1]};
        end
      end
      SEL_ROT: begin
        if (dir == DIR_RIGHT) nv = {v[0], v[WIDTH-1:1]};
        else                  nv = {v[WIDTH-2:0], v[WIDTH-1]};
      end
      default: begin
        nv = v;
        ov = 1'b0;
      end
    endcase
    return {ov, nv};
  endfunction

  always_comb begin
    {midOvf, midValue} = stepOnce(value_i, direction_i, sel_i);
    {finOvf, finValue} = stepOnce(midValue, direction_i, sel_i);
    value_o    = midValue;
    overflow_o = midOvf;
    if (double_i) begin
      value_o    = finValue;
      overflow_o = midOvf | finOvf;
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with valid/ready request and result handshakes and a sticky overflow flag.
// Define SEQ_SHIFTER_FAST_EN to move two positions per cycle while at least two remain.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int bit_size = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [bit_size-1:0]         data,
  input  logic [$clog2(bit_size)-1:0] num_shift,
  input  logic                        direction,
  input  logic [1:0]                  sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bit_size-1:0]         out,
  output logic                        overflow,
  output logic                        busy
);

  localparam int CW = $clog2(bit_size);

  state_e            state_q, state_d;
  logic [bit_size-1:0] out_q, out_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     count_q, count_d;
  logic              dir_q, dir_d;
  logic [1:0]        sel_q, sel_d;

  logic              useDouble;
  logic [CW-1:0]     stepAmt;
  logic [bit_size-1:0] stepValue;
  logic              stepOvf;

`ifdef SEQ_SHIFTER_FAST_EN
  assign useDouble = (count_q > CW'(1));
`else
  assign useDouble = 1'b0;
`endif

  assign stepAmt = useDouble ? CW'(2) : CW'(1);

  seq_shift_step #(
    .WIDTH(bit_size)
  ) uStep (
    .value_i    (out_q),
    .direction_i(dir_q),
    .sel_i      (sel_q),
    .double_i   (useDouble),
    .value_o    (stepValue),
    .overflow_o (stepOvf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      dir_q   <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
    end
  end

  // The zero-count SHIFT cycle is what gives num_shift=0 its single-edge latency.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_d   = data;
          dir_d   = direction;
          sel_d   = sel;
          ovf_d   = 1'b0;
          count_d = num_shift;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q != '0) begin
          out_d   = stepValue;
          ovf_d   = ovf_q | stepOvf;
          count_d = count_q - stepAmt;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed cases plus random requests scored against an arithmetic model
// of each shift kind; latency, hold-off, busy rejection and mid-operation reset are covered.
module tb_seq_shifter;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [2:0] num_shift;
  logic       direction;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_shifter #(
    .bit_size(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .num_shift(num_shift),
    .direction(direction),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Result of shifting the whole operand by n positions, written as plain arithmetic.
  function automatic void refModel(input logic [7:0] d, input int n, input logic dir,
                                   input logic [1:0] s, output logic [7:0] r, output logic o);
    int dv;
    int topBits;
    dv = int'(d);
    r  = d;
    o  = 1'b0;
    case (s)
      2'd0: begin
        if (!dir) begin
          r = 8'((dv << n) & 255);
          o = ((dv << n) >> 8) != 0;
        end else begin
          r = 8'(dv >> n);
        end
      end
      2'd1: begin
        if (!dir) begin
          r = 8'((dv << n) & 255);
          topBits = dv >> (7 - n);
          o = (topBits != 0) && (topBits != ((1 << (n + 1)) - 1));
        end else begin
          r = 8'((dv >> n) | ((d[7] ? 255 : 0) << (8 - n)) & 255);
        end
      end
      2'd2: begin
        if (!dir) r = 8'(((dv << n) | (dv >> (8 - n))) & 255);
        else      r = 8'(((dv >> n) | (dv << (8 - n))) & 255);
      end
      default: begin
        r = d;
        o = 1'b0;
      end
    endcase
  endfunction

  function automatic int expectedLatency(input int n);
`ifdef SEQ_SHIFTER_FAST_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Presents one request, then scrambles the inputs while counting edges until out_valid.
  task automatic applyStimulus(input logic [7:0] d, input int n, input logic dir,
                               input logic [1:0] s, output int lat);
    @(negedge clk);
    checkBit("readyBeforeAccept", in_ready, 1'b1);
    in_valid  = 1'b1;
    data      = d;
    num_shift = 3'(n);
    direction = dir;
    sel       = s;
    @(posedge clk);
    #1;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      in_valid  = 1'($urandom_range(0, 1));
      data      = 8'($urandom);
      num_shift = 3'($urandom);
      direction = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expOut, input logic expOvf);
    checkWord({tag, "Out"}, 32'(out), 32'(expOut));
    checkBit({tag, "Ovf"}, overflow, expOvf);
    checkBit({tag, "Valid"}, out_valid, 1'b1);
    checkBit({tag, "InReady"}, in_ready, 1'b0);
  endtask

  task automatic runOp(input logic [7:0] d, input int n, input logic dir,
                       input logic [1:0] s, input int hold);
    logic [7:0] expOut;
    logic       expOvf;
    int         lat;
    refModel(d, n, dir, s, expOut, expOvf);
    applyStimulus(d, n, dir, s, lat);
    out_ready = (hold == 0);
    checkWord("latency", 32'(lat), 32'(expectedLatency(n)));
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold", expOut, expOvf);
      @(negedge clk);
      in_valid = 1'b1;
      data     = 8'hFF;
      @(posedge clk);
      #1;
    end
    checkOutput("result", expOut, expOvf);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkBit("validPulse", out_valid, 1'b0);
    checkBit("readyAfter", in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] expOut;
    logic       expOvf;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    data      = 8'h00;
    num_shift = 3'd0;
    direction = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;

    #12;
    checkBit("rstInReady", in_ready, 1'b1);
    checkWord("rstOut", 32'(out), 32'h0);
    checkBit("rstOvf", overflow, 1'b0);
    checkBit("rstValid", out_valid, 1'b0);
    checkBit("rstBusy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkBit("idleReady", in_ready, 1'b1);
    checkBit("idleBusy", busy, 1'b0);

    runOp(8'h96, 3, 1'b0, 2'd0, 0);
    runOp(8'h96, 2, 1'b1, 2'd1, 0);
    runOp(8'h96, 3, 1'b0, 2'd2, 0);
    runOp(8'h96, 3, 1'b1, 2'd2, 0);
    runOp(8'h30, 2, 1'b0, 2'd1, 0);
    runOp(8'h30, 1, 1'b0, 2'd1, 0);
    runOp(8'hA5, 4, 1'b0, 2'd3, 0);
    runOp(8'h5A, 0, 1'b0, 2'd0, 5);

    // Abort a long operation with reset partway through.
    @(negedge clk);
    in_valid  = 1'b1;
    data      = 8'hFF;
    num_shift = 3'd7;
    direction = 1'b0;
    sel       = 2'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    refModel(8'hFF, 3, 1'b0, 2'd0, expOut, expOvf);
    checkWord("midOut", 32'(out), 32'(expOut));
    checkBit("midOvf", overflow, expOvf);
    checkBit("midBusy", busy, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    checkWord("abortOut", 32'(out), 32'h0);
    checkBit("abortOvf", overflow, 1'b0);
    checkBit("abortValid", out_valid, 1'b0);
    checkBit("abortBusy", busy, 1'b0);
    checkBit("abortReady", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    runOp(8'h01, 7, 1'b0, 2'd0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] rd;
      int         rn;
      logic       rdir;
      logic [1:0] rs;
      int         rh;
      rd   = 8'($urandom);
      rn   = int'($urandom_range(0, 7));
      rdir = 1'($urandom);
      rs   = 2'($urandom);
      rh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      runOp(rd, rn, rdir, rs, rh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
